hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//   Pipeline sequencer for the 5-stage core. Drives the hold and flush controls of the PC and of the
//   IF/ID, ID/EX and EX/MEM pipeline registers. Cases handled: load-use bubbles, taken-branch flushes
//   (branch resolved in MEM), and whole-pipe freezes while a multi-cycle data-memory access waits for ack.
//   Sits beside the decode stage; the pipeline registers gain a hold enable driven from here.
// PARAMETERS
//   MEM_TIMEOUT  16  max freeze cycles per data-memory access before ERR (>=2)
//   WAIT_W       5   width of wait counter; must hold MEM_TIMEOUT
//   PERF_W       32  width of performance counters (HAZARD_PERF_EN only)
// PORTS
//   clk             in   1      clock, rising edge
//   rst             in   1      asynchronous reset, active-high
//   id_rs           in   5      rs field of instruction in ID
//   id_rt           in   5      rt field of instruction in ID
//   id_uses_rt      in   1      ID instruction reads rt as a source
//   ex_memread      in   1      instruction in EX is a load
//   ex_regrt        in   5      load destination (rt) in EX
//   mem_branch_tkn  in   1      branch in MEM resolved taken
//   dmem_req        in   1      MEM stage data access active this cycle
//   dmem_ack        in   1      data memory completes access this cycle
//   pc_hold         out  1      PC keeps value
//   ifid_hold       out  1      IF/ID keeps value
//   idex_hold       out  1      ID/EX keeps value
//   exmem_hold      out  1      EX/MEM keeps value
//   ifid_flush      out  1      IF/ID loads bubble
//   idex_flush      out  1      ID/EX loads bubble (all control bits Disable)
//   exmem_flush     out  1      EX/MEM loads bubble
//   mem_err         out  1      sticky access-timeout error
//   state           out  2      FSM state (debug)
//   lu_cnt/mw_cnt/fl_cnt out PERF_W  perf counters (HAZARD_PERF_EN)
// BEHAVIOUR
//   Outputs are combinational from state and inputs; state, wait_cnt and perf counters are registered.
//   Reset (async): state=RUN, wait_cnt=0, mem_err=0, counters=0; all hold/flush outputs 0 during reset.
//   load_use = ex_memread & ex_regrt!=0 & (ex_regrt==id_rs | (id_uses_rt & ex_regrt==id_rt)).
//   States: RUN=0, MWAIT=1, ERR=3 (2 unused -> treated as ERR).
//   RUN, priority high->low:
//     1 mem_branch_tkn: ifid_flush=idex_flush=exmem_flush=1, no holds (PC takes target); next RUN.
//     2 dmem_req & !dmem_ack: pc/ifid/idex/exmem_hold=1, no flushes; wait_cnt<=1; next MWAIT.
//     3 load_use: pc_hold=ifid_hold=1, idex_flush=1 (one bubble); next RUN.
//     else: all 0; next RUN.
//   Branch in RUN overrides a simultaneous load_use or dmem_req: the flush wins.
//   The MEM-stage access is treated as complete (dmem_ack ignored) in that cycle.
//   MWAIT: all four holds=1, flushes=0; branch and load_use ignored (pipe frozen, re-evaluated after).
//     dmem_ack: holds drop to 0 in the ack cycle; next RUN; wait_cnt<=0.
//     no ack and wait_cnt==MEM_TIMEOUT-1: next ERR; else wait_cnt<=wait_cnt+1.
//   ERR: all holds=1, mem_err=1; leaves only via rst.
//   Latency: load-use costs exactly 1 cycle. A branch costs 3 flushed slots. A memory wait costs N cycles
//   (the cycles until ack).
//   Reset mid-MWAIT: immediate return to RUN, holds released asynchronously.
// CONFIGURATION
//   `HAZARD_PERF_EN defined: saturating counters, one increment per cycle:
//     lu_cnt for RUN load-use bubbles; mw_cnt for each cycle with exmem_hold=1; fl_cnt for each branch flush.
//   Undefined: no counter registers; lu_cnt/mw_cnt/fl_cnt ports present, tied to 0.
// TESTING
//   ex_memread=1, ex_regrt=8, id_rs=8 -> pc_hold=ifid_hold=idex_flush=1 for 1 cycle, then all 0.
//   Same with ex_regrt=0 -> no stall.
//   id_uses_rt=0, id_rt=8, ex_regrt=8 -> no stall.
//   mem_branch_tkn=1 together with load_use -> three flushes=1, pc_hold=0, state stays RUN.
//   dmem_req=1, ack after 4 cycles -> holds=1 for 4 cycles, 0 in ack cycle.
//   With PERF on: mw_cnt=4.
//   dmem_req=1, no ack, MEM_TIMEOUT=16 -> state=ERR, mem_err=1 after 16 frozen cycles.
//   rst pulse -> RUN, mem_err=0.
//   rst asserted in MWAIT cycle 2 -> holds 0 immediately, state=0, wait_cnt=0.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: hazard sources from ID/EX/MEM and the hold/flush/status controls.
// master = pipeline side (drives hazard sources), slave = hazard controller.
interface hazard_ctrl_if #(
  parameter int PERF_W = 32
);
  logic [4:0]        id_rs;
  logic [4:0]        id_rt;
  logic              id_uses_rt;
  logic              ex_memread;
  logic [4:0]        ex_regrt;
  logic              mem_branch_tkn;
  logic              dmem_req;
  logic              dmem_ack;
  logic              pc_hold;
  logic              ifid_hold;
  logic              idex_hold;
  logic              exmem_hold;
  logic              ifid_flush;
  logic              idex_flush;
  logic              exmem_flush;
  logic              mem_err;
  logic [1:0]        state;
  logic [PERF_W-1:0] lu_cnt;
  logic [PERF_W-1:0] mw_cnt;
  logic [PERF_W-1:0] fl_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_memread, ex_regrt,
           mem_branch_tkn, dmem_req, dmem_ack,
    input  pc_hold, ifid_hold, idex_hold, exmem_hold,
           ifid_flush, idex_flush, exmem_flush, mem_err, state,
           lu_cnt, mw_cnt, fl_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_memread, ex_regrt,
           mem_branch_tkn, dmem_req, dmem_ack,
    output pc_hold, ifid_hold, idex_hold, exmem_hold,
           ifid_flush, idex_flush, exmem_flush, mem_err, state,
           lu_cnt, mw_cnt, fl_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard sequencer for the 5-stage core: load-use bubbles, taken-branch flushes, data-memory freezes.
// Optional saturating perf counters lu_cnt/mw_cnt/fl_cnt are enabled by defining HAZARD_PERF_EN.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int WAIT_W      = 5,
  parameter int PERF_W      = 32
) (
  input  logic        clk,
  input  logic        rst,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_MWAIT = 2'd1,
    ST_RSVD  = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_err_q, mem_err_d;

  logic load_use;
  logic pc_hold_c, ifid_hold_c, idex_hold_c, exmem_hold_c;
  logic ifid_flush_c, idex_flush_c, exmem_flush_c;
  logic lu_evt, fl_evt;

  assign load_use = hz.ex_memread && (hz.ex_regrt != 5'd0) &&
                    ((hz.ex_regrt == hz.id_rs) ||
                     (hz.id_uses_rt && (hz.ex_regrt == hz.id_rt)));

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    pc_hold_c     = 1'b0;
    ifid_hold_c   = 1'b0;
    idex_hold_c   = 1'b0;
    exmem_hold_c  = 1'b0;
    ifid_flush_c  = 1'b0;
    idex_flush_c  = 1'b0;
    exmem_flush_c = 1'b0;
    lu_evt        = 1'b0;
    fl_evt        = 1'b0;

    case (state_q)
      ST_RUN: begin
        // A taken branch squashes the MEM access too, so its ack is irrelevant this cycle.
        if (hz.mem_branch_tkn) begin
          ifid_flush_c  = 1'b1;
          idex_flush_c  = 1'b1;
          exmem_flush_c = 1'b1;
          fl_evt        = 1'b1;
        end else if (hz.dmem_req && !hz.dmem_ack) begin
          pc_hold_c    = 1'b1;
          ifid_hold_c  = 1'b1;
          idex_hold_c  = 1'b1;
          exmem_hold_c = 1'b1;
          wait_cnt_d   = WAIT_W'(1);
          state_d      = ST_MWAIT;
        end else if (load_use) begin
          pc_hold_c    = 1'b1;
          ifid_hold_c  = 1'b1;
          idex_flush_c = 1'b1;
          lu_evt       = 1'b1;
        end
      end

      ST_MWAIT: begin
        if (hz.dmem_ack) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else begin
          pc_hold_c    = 1'b1;
          ifid_hold_c  = 1'b1;
          idex_hold_c  = 1'b1;
          exmem_hold_c = 1'b1;
          if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
            state_d = ST_ERR;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end
      end

      // ERR and the unused encoding both freeze the pipe until reset.
      default: begin
        pc_hold_c    = 1'b1;
        ifid_hold_c  = 1'b1;
        idex_hold_c  = 1'b1;
        exmem_hold_c = 1'b1;
        state_d      = ST_ERR;
      end
    endcase

    mem_err_d = mem_err_q || (state_d == ST_ERR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  // Gate with rst so controls are released asynchronously, whatever the inputs are doing.
  assign hz.pc_hold     = pc_hold_c     && !rst;
  assign hz.ifid_hold   = ifid_hold_c   && !rst;
  assign hz.idex_hold   = idex_hold_c   && !rst;
  assign hz.exmem_hold  = exmem_hold_c  && !rst;
  assign hz.ifid_flush  = ifid_flush_c  && !rst;
  assign hz.idex_flush  = idex_flush_c  && !rst;
  assign hz.exmem_flush = exmem_flush_c && !rst;
  assign hz.mem_err     = mem_err_q;
  assign hz.state       = state_q;

`ifdef HAZARD_PERF_EN
  logic              perf_evt [3];
  logic [PERF_W-1:0] perf_cnt_q [3];
  logic [PERF_W-1:0] perf_cnt_d [3];

  assign perf_evt[0] = lu_evt;
  assign perf_evt[1] = exmem_hold_c;
  assign perf_evt[2] = fl_evt;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_perf
      always_comb begin
        perf_cnt_d[gi] = perf_cnt_q[gi];
        if (perf_evt[gi] && !(&perf_cnt_q[gi])) begin
          perf_cnt_d[gi] = perf_cnt_q[gi] + PERF_W'(1);
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          perf_cnt_q[gi] <= '0;
        end else begin
          perf_cnt_q[gi] <= perf_cnt_d[gi];
        end
      end
    end
  endgenerate

  assign hz.lu_cnt = perf_cnt_q[0];
  assign hz.mw_cnt = perf_cnt_q[1];
  assign hz.fl_cnt = perf_cnt_q[2];
`else
  logic unused_evt;
  assign unused_evt = lu_evt ^ fl_evt;
  assign hz.lu_cnt  = {PERF_W{1'b0}};
  assign hz.mw_cnt  = {PERF_W{1'b0}};
  assign hz.fl_cnt  = {PERF_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, branch flush, memory freeze, timeout, async reset.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  hazard_ctrl_if #(.PERF_W(32)) hz ();

  hazard_ctrl #(
    .MEM_TIMEOUT(16),
    .WAIT_W     (5),
    .PERF_W     (32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz (hz.slave)
  );

  always #5 clk = ~clk;

  // {pc_hold, ifid_hold, idex_hold, exmem_hold, ifid_flush, idex_flush, exmem_flush}
  logic [6:0] ctl;
  assign ctl = {hz.pc_hold, hz.ifid_hold, hz.idex_hold, hz.exmem_hold,
                hz.ifid_flush, hz.idex_flush, hz.exmem_flush};

  localparam logic [6:0] C_NONE   = 7'b000_0000;
  localparam logic [6:0] C_LU     = 7'b110_0010;
  localparam logic [6:0] C_FLUSH  = 7'b000_0111;
  localparam logic [6:0] C_FREEZE = 7'b111_1000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                       input logic memrd, input logic [4:0] regrt, input logic br,
                       input logic req, input logic ack);
    hz.id_rs          = rs;
    hz.id_rt          = rt;
    hz.id_uses_rt     = uses_rt;
    hz.ex_memread     = memrd;
    hz.ex_regrt       = regrt;
    hz.mem_branch_tkn = br;
    hz.dmem_req       = req;
    hz.dmem_ack       = ack;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    $display("tb_hazard_ctrl start");
    // Reset held with hazards present: controls must stay low.
    drive(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0);
    chk("reset_ctl", 32'(ctl), 32'(C_NONE));
    chk("reset_state", 32'(hz.state), 32'd0);
    chk("reset_err", 32'(hz.mem_err), 32'd0);
    chk("reset_lu_cnt", hz.lu_cnt, 32'd0);
    tick();
    rst = 1'b0;
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("idle_ctl", 32'(ctl), 32'(C_NONE));

    // Load-use on rs: one bubble, then the load has moved on.
    tick();
    drive(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
    $display("txn load_use_rs ctl=%b", ctl);
    chk("lu_rs_ctl", 32'(ctl), 32'(C_LU));
    tick();
    chk("lu_rs_state", 32'(hz.state), 32'd0);
    drive(5'd8, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("lu_rs_after", 32'(ctl), 32'(C_NONE));

    // r0 destination never stalls.
    tick();
    drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    $display("txn load_use_r0 ctl=%b", ctl);
    chk("lu_r0_ctl", 32'(ctl), 32'(C_NONE));

    // rt match only counts when the ID instruction reads rt.
    tick();
    drive(5'd3, 5'd8, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
    $display("txn load_use_rt_unused ctl=%b", ctl);
    chk("lu_rt_unused", 32'(ctl), 32'(C_NONE));
    drive(5'd3, 5'd8, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
    $display("txn load_use_rt_used ctl=%b", ctl);
    chk("lu_rt_used", 32'(ctl), 32'(C_LU));

    // Branch beats a simultaneous load-use.
    tick();
    drive(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    $display("txn branch_lu ctl=%b", ctl);
    chk("br_lu_ctl", 32'(ctl), 32'(C_FLUSH));
    tick();
    chk("br_lu_state", 32'(hz.state), 32'd0);

    // Branch beats a pending memory access.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    $display("txn branch_req ctl=%b", ctl);
    chk("br_req_ctl", 32'(ctl), 32'(C_FLUSH));
    tick();
    chk("br_req_state", 32'(hz.state), 32'd0);

    // Memory wait: ack on the fifth cycle -> four frozen cycles.
    for (int i = 0; i < 4; i++) begin
      drive(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, (i == 2), 1'b1, 1'b0);
      $display("txn mwait cyc=%0d ctl=%b state=%0d", i, ctl, hz.state);
      chk($sformatf("mw_ctl_%0d", i), 32'(ctl), 32'(C_FREEZE));
      tick();
      chk($sformatf("mw_state_%0d", i), 32'(hz.state), 32'd1);
    end
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    $display("txn mwait ack ctl=%b", ctl);
    chk("mw_ack_ctl", 32'(ctl), 32'(C_NONE));
    tick();
    chk("mw_ack_state", 32'(hz.state), 32'd0);
`ifdef HAZARD_PERF_EN
    chk("perf_mw_cnt", hz.mw_cnt, 32'd4);
    chk("perf_lu_cnt", hz.lu_cnt, 32'd2);
    chk("perf_fl_cnt", hz.fl_cnt, 32'd2);
`else
    chk("perf_mw_off", hz.mw_cnt, 32'd0);
    chk("perf_fl_off", hz.fl_cnt, 32'd0);
`endif

    // Timeout: 16 frozen cycles without ack -> ERR.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) tick();
    chk("to_state_15", 32'(hz.state), 32'd1);
    chk("to_err_15", 32'(hz.mem_err), 32'd0);
    chk("to_ctl_15", 32'(ctl), 32'(C_FREEZE));
    tick();
    $display("txn timeout state=%0d mem_err=%0d", hz.state, hz.mem_err);
    chk("to_state_16", 32'(hz.state), 32'd3);
    chk("to_err_16", 32'(hz.mem_err), 32'd1);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
    tick();
    chk("err_sticky_state", 32'(hz.state), 32'd3);
    chk("err_sticky_ctl", 32'(ctl), 32'(C_FREEZE));

    // Reset pulse recovers.
    rst = 1'b1;
    #1;
    chk("rstp_ctl", 32'(ctl), 32'(C_NONE));
    chk("rstp_state", 32'(hz.state), 32'd0);
    chk("rstp_err", 32'(hz.mem_err), 32'd0);
    tick();
    rst = 1'b0;
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    $display("txn rst_pulse state=%0d mem_err=%0d", hz.state, hz.mem_err);
    chk("rstp_idle", 32'(ctl), 32'(C_NONE));

    // Reset in MWAIT cycle 2 releases holds immediately.
    tick();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    chk("rmw_pre_ctl", 32'(ctl), 32'(C_FREEZE));
    chk("rmw_pre_state", 32'(hz.state), 32'd1);
    rst = 1'b1;
    #1;
    $display("txn rst_in_mwait ctl=%b state=%0d", ctl, hz.state);
    chk("rmw_ctl", 32'(ctl), 32'(C_NONE));
    chk("rmw_state", 32'(hz.state), 32'd0);
    tick();
    rst = 1'b0;
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    // Fresh wait starts from a cleared counter: 15 more edges stays in MWAIT.
    for (int i = 0; i < 15; i++) tick();
    chk("rmw_cnt_clear", 32'(hz.state), 32'd1);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    tick();
    chk("rmw_final_state", 32'(hz.state), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
